dwc_line_feeder: RTL and testbench
==================================

# dwc_line_feeder

Raster-to-band line buffer that drives the six-row input interface of the depthwise 3x3 convolution unit. It accepts one pixel per handshake in row-major order and stores rows in six circular line banks. For each band it streams one column per cycle, presenting six vertically aligned pixels on `buffer0..buffer5` with a contiguous `out_valid` burst. Consecutive bands overlap by two rows, so each band yields four output rows downstream.

## Interface
Parameters:
- `DATA_W`, 8, pixel width (signed two's complement)
- `MAX_W`, 64, maximum image width; sets bank depth
- `MAX_H`, 64, maximum image height
- `WW`, `$clog2(MAX_W+1)`, width of the `img_w` field
- `HW`, `$clog2(MAX_H+1)`, width of the `img_h` field

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; latches `img_w`/`img_h`; ignored while `busy`
- `img_w`  in  WW  image width, legal range 3..MAX_W
- `img_h`  in  HW  image height, legal range 3..MAX_H
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  feeder can accept a pixel
- `s_data`  in  DATA_W  input pixel, row-major order
- `buffer0..buffer5`  out  DATA_W each  band rows 0..5 of the current column; registered
- `out_valid`  out  1  drives the downstream `in_valid`
- `busy`  out  1  high from the accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last column of the last band

## Operation
- States: IDLE, FILL, STREAM, DONE.
- IDLE -> FILL on `start` with a legal config.
  - For an illegal config (w<3, h<3, w>MAX_W or h>MAX_H), IDLE -> DONE instead; no pixels are accepted and nothing is emitted.
- Band count: B = ceil((img_h-2)/4). Band b covers image rows 4b..4b+5.
- FILL:
  - `s_ready`=1. A pixel transfers when `s_valid && s_ready`.
  - The write column counter wraps at `img_w`, then advances the write bank (mod 6).
  - Band 0 fills min(6, img_h) rows. Each later band fills min(4, remaining) rows.
  - FILL -> STREAM when the band's last pixel transfers.
- STREAM:
  - `s_ready`=0. Read column c = 0..img_w-1, one per cycle, with no gaps.
  - `bufferK` = pixel (row 4b+K, col c). Any row >= img_h drives 0.
  - Bank mapping: bufferK reads bank (base+K) mod 6. `base` advances by 4 (mod 6) at the end of each band.
  - At the end of the band: go to FILL if bands remain, otherwise DONE.
- DONE: `done`=1 for one cycle, `busy` drops in the same cycle, then IDLE.
- Total pixels accepted equals img_w*img_h exactly. Extra `s_valid` beats are never accepted.
- Reset, including mid-FILL or mid-STREAM:
  - Immediate return to IDLE.
  - `s_ready`, `out_valid`, `busy`, `done` = 0; `buffer0..5` = 0; `base` and all counters = 0.
  - Bank contents are don't-care.

## Timing
- Banks use a registered read (1 cycle) and the outputs are registered.
- First `out_valid` appears 2 cycles after the band's final accepted pixel.
- `out_valid` is high for exactly img_w consecutive cycles per band (img_w+2 with the padding macro).
- `s_ready` rises the cycle after the last `out_valid` of a non-final band.
- `done` asserts the cycle after the last `out_valid` of the final band.
- `buffer0..5` hold their last value when `out_valid`=0.
- A `start` arriving in the same cycle as `done` is ignored.

## Configuration
- `DWC_FEEDER_HPAD_EN` defined:
  - Each band emits one zero column before column 0 and one after column img_w-1: img_w+2 contiguous `out_valid` cycles.
  - Padding columns drive all six buffers to 0, including rows that exist.
- Undefined: exactly img_w columns per band, no padding.

## Test plan
- img_w=4, img_h=6, pixel = row*16+col, `s_valid` held high:
  - 24 pixels accepted, then one 4-cycle `out_valid` burst where column c gives bufferK = K*16+c.
  - `done` the cycle after the burst.
- img_w=4, img_h=10:
  - 2 bands. Band 1 is preceded by exactly 16 accepted pixels.
  - Band 1 column 2: buffer0..5 = 66, 82, 98, 114, 130, 146.
- img_w=3, img_h=8:
  - Band 1 uses rows 4..7; buffer4 = buffer5 = 0 on all 3 columns; total pixels accepted = 24.
- Backpressure: img_w=5, img_h=6, `s_valid` toggling 1,0,1,0:
  - Output identical to the continuous case; `s_ready` stays 0 throughout STREAM; burst still 5 contiguous cycles.
- `rst_n` pulsed low during the 2nd STREAM cycle:
  - All outputs 0 immediately. A new `start` (4x6) then behaves exactly as the first test.
- With `DWC_FEEDER_HPAD_EN`, img_w=4, img_h=6:
  - 6-cycle burst; first and last cycles are all zeros; middle 4 cycles match the first test.
  - `start` with img_h=2: `done` pulse with zero pixels accepted and no `out_valid`.

Source files
------------

// File: rtl/dwc_line_feeder.sv
// dwc_line_feeder: raster-to-band line buffer feeding six vertically aligned rows per column.
// Define DWC_FEEDER_HPAD_EN to emit one zero column on each side of every band.
module dwc_line_feeder #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 64,
    parameter int MAX_H  = 64,
    parameter int WW     = $clog2(MAX_W + 1),
    parameter int HW     = $clog2(MAX_H + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WW-1:0]     img_w,
    input  logic [HW-1:0]     img_h,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] buffer0,
    output logic [DATA_W-1:0] buffer1,
    output logic [DATA_W-1:0] buffer2,
    output logic [DATA_W-1:0] buffer3,
    output logic [DATA_W-1:0] buffer4,
    output logic [DATA_W-1:0] buffer5,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);
    localparam int AW = $clog2(MAX_W);
    localparam int CW = WW + 1;
    localparam int RW = HW + 3;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t            state;
    logic [WW-1:0]     w_q, wcol;
    logic [HW-1:0]     h_q;
    logic [RW-1:0]     wrow, row_base, h_ext, fill_end;
    logic [2:0]        wbank, base, next_bank, base_next;
    logic [CW-1:0]     scnt, ncols;
    logic [AW-1:0]     raddr;
    logic              legal, xfer, last_col, more, issue, pad, v1, z1;
    logic [2:0]        bank [6];
    logic [5:0]        keep;
    logic [DATA_W-1:0] mem  [6][MAX_W];
    logic [DATA_W-1:0] rd   [6];
    logic [DATA_W-1:0] buf_q [6];

    assign legal     = img_w >= WW'(3) && img_w <= WW'(MAX_W) && img_h >= HW'(3) && img_h <= HW'(MAX_H);
    assign xfer      = s_valid && s_ready;
    assign last_col  = wcol == w_q - WW'(1);
    assign next_bank = wbank == 3'd5 ? 3'd0 : wbank + 3'd1;
    assign base_next = base >= 3'd2 ? base - 3'd2 : base + 3'd4;
    assign h_ext     = RW'(h_q);
    assign more      = row_base + RW'(6) < h_ext;
    assign fill_end  = more ? row_base + RW'(6) : h_ext;
    assign issue     = state == STREAM && scnt < ncols;

`ifdef DWC_FEEDER_HPAD_EN
    assign ncols = CW'(w_q) + CW'(2);
    assign pad   = scnt == '0 || scnt == ncols - CW'(1);
    assign raddr = pad ? '0 : AW'(scnt - CW'(1));
`else
    assign ncols = CW'(w_q);
    assign pad   = 1'b0;
    assign raddr = AW'(scnt);
`endif

    // Row K of the band lives in bank (base+K) mod 6; rows past the image bottom read as zero.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            bank[k] = ({1'b0, base} + 4'(k) >= 4'd6) ? base + 3'(k) - 3'd6 : base + 3'(k);
            keep[k] = row_base + RW'(k) < h_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) mem[wbank][wcol[AW-1:0]] <= s_data;
        for (int k = 0; k < 6; k++) rd[k] <= mem[bank[k]][raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            z1        <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < 6; k++) buf_q[k] <= '0;
        end else begin
            v1        <= issue;
            z1        <= pad;
            out_valid <= v1;
            if (v1) for (int k = 0; k < 6; k++) buf_q[k] <= (z1 || !keep[k]) ? '0 : rd[k];
        end
    end

    // STREAM lingers two extra cycles so the read pipeline drains before the next FILL or DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_q      <= '0;
            h_q      <= '0;
            wcol     <= '0;
            wrow     <= '0;
            wbank    <= '0;
            base     <= '0;
            row_base <= '0;
            scnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    w_q      <= img_w;
                    h_q      <= img_h;
                    wcol     <= '0;
                    wrow     <= '0;
                    wbank    <= '0;
                    base     <= '0;
                    row_base <= '0;
                    scnt     <= '0;
                    if (legal) begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                FILL: if (xfer) begin
                    wcol <= last_col ? '0 : wcol + WW'(1);
                    if (last_col) begin
                        wbank <= next_bank;
                        wrow  <= wrow + RW'(1);
                        if (wrow + RW'(1) == fill_end) begin
                            state   <= STREAM;
                            s_ready <= 1'b0;
                            scnt    <= '0;
                        end
                    end
                end
                STREAM: begin
                    scnt <= scnt + CW'(1);
                    if (scnt == ncols + CW'(1)) begin
                        scnt     <= '0;
                        row_base <= row_base + RW'(4);
                        base     <= base_next;
                        if (more) begin
                            state   <= FILL;
                            s_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign buffer0 = buf_q[0];
    assign buffer1 = buf_q[1];
    assign buffer2 = buf_q[2];
    assign buffer3 = buf_q[3];
    assign buffer4 = buf_q[4];
    assign buffer5 = buf_q[5];
endmodule

// File: tb/tb_dwc_line_feeder.sv
// tb_dwc_line_feeder: directed self-checking bench for the six-row band feeder.
module tb_dwc_line_feeder;
`ifdef DWC_FEEDER_HPAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, s_valid, s_ready, out_valid, busy, done;
    logic [6:0] img_w, img_h;
    logic [7:0] s_data, buffer0, buffer1, buffer2, buffer3, buffer4, buffer5;
    logic [7:0] bufs [6];

    int tests_run = 0;
    int tests_failed = 0;
    int accepted, n_beats, n_bursts, sready_bad;
    bit timed_out, busy_seen, busy_at_done;
    int bstart_acc [8];
    int bgap [8];
    int blen [8];
    bit sr_after [8];
    bit done_after [8];
    logic [7:0] cap [32][6];

    assign bufs[0] = buffer0;
    assign bufs[1] = buffer1;
    assign bufs[2] = buffer2;
    assign bufs[3] = buffer3;
    assign bufs[4] = buffer4;
    assign bufs[5] = buffer5;

    always #5 clk = ~clk;

    dwc_line_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .buffer0(buffer0), .buffer1(buffer1), .buffer2(buffer2),
        .buffer3(buffer3), .buffer4(buffer4), .buffer5(buffer5),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    // Runs one image with pixel = row*16+col and records bursts, beats and handshake events.
    task automatic run_image(input int w, input int h, input bit tog);
        int idx, cyc, last_acc;
        bit prev_ov, seen_done, ph;
        accepted = 0; n_beats = 0; n_bursts = 0; sready_bad = 0;
        busy_at_done = 1'b1; idx = 0; last_acc = 0; prev_ov = 1'b0; seen_done = 1'b0; ph = 1'b0;
        @(negedge clk);
        start = 1'b1; img_w = 7'(w); img_h = 7'(h); s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        cyc = 0;
        while (!seen_done && cyc < 2000) begin
            if (out_valid) begin
                if (!prev_ov && n_bursts < 8) begin
                    bstart_acc[n_bursts] = accepted;
                    bgap[n_bursts] = cyc - last_acc;
                    blen[n_bursts] = 0;
                    n_bursts++;
                end
                if (n_bursts > 0) blen[n_bursts-1]++;
                if (n_beats < 32) for (int k = 0; k < 6; k++) cap[n_beats][k] = bufs[k];
                n_beats++;
                if (s_ready) sready_bad++;
            end else if (prev_ov && n_bursts > 0) begin
                sr_after[n_bursts-1] = s_ready;
                done_after[n_bursts-1] = done;
            end
            if (done) begin
                seen_done = 1'b1;
                busy_at_done = busy;
            end
            prev_ov = out_valid;
            s_valid = tog ? !ph : 1'b1;
            ph = !ph;
            s_data = 8'((idx / w) * 16 + (idx % w));
            if (s_valid && s_ready) begin
                accepted++;
                idx++;
                last_acc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        timed_out = !seen_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; img_w = '0; img_h = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({s_ready, out_valid, busy, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000", {s_ready, out_valid, busy, done});
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (bufs[k] !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_buffer%0d: got %0d expected 0", k, bufs[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({s_ready, busy} !== 2'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b expected 00", {s_ready, busy});
        end
    endtask

    task automatic test_basic(input string tag);
        run_image(4, 6, 1'b0);
        tests_run++;
        if (timed_out) begin tests_failed++; $display("FAIL %s_timeout: got no done expected done", tag); end
        tests_run++;
        if (accepted !== 24) begin tests_failed++; $display("FAIL %s_accepted: got %0d expected 24", tag, accepted); end
        tests_run++;
        if (n_bursts !== 1) begin tests_failed++; $display("FAIL %s_bursts: got %0d expected 1", tag, n_bursts); end
        tests_run++;
        if (blen[0] !== 4 + 2 * PAD) begin tests_failed++; $display("FAIL %s_burst_len: got %0d expected %0d", tag, blen[0], 4 + 2 * PAD); end
        tests_run++;
        if (bstart_acc[0] !== 24) begin tests_failed++; $display("FAIL %s_acc_before_burst: got %0d expected 24", tag, bstart_acc[0]); end
        tests_run++;
        if (bgap[0] !== 3) begin tests_failed++; $display("FAIL %s_latency: got %0d expected 3", tag, bgap[0]); end
        tests_run++;
        if (done_after[0] !== 1'b1) begin tests_failed++; $display("FAIL %s_done_after_burst: got %0d expected 1", tag, done_after[0]); end
        tests_run++;
        if (busy_seen !== 1'b1 || busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy: got start=%0d done=%0d expected start=1 done=0", tag, busy_seen, busy_at_done);
        end
        tests_run++;
        if (sready_bad !== 0) begin tests_failed++; $display("FAIL %s_sready_stream: got %0d expected 0", tag, sready_bad); end
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (cap[c+PAD][k] !== 8'(k * 16 + c)) begin
                    tests_failed++;
                    $display("FAIL %s_col%0d_buf%0d: got %0d expected %0d", tag, c, k, cap[c+PAD][k], k * 16 + c);
                end
            end
    endtask

    task automatic test_two_bands();
        int exp_col2 [6] = '{66, 82, 98, 114, 130, 146};
        run_image(4, 10, 1'b0);
        tests_run++;
        if (timed_out || accepted !== 40) begin
            tests_failed++;
            $display("FAIL two_accepted: got %0d (timeout %0d) expected 40", accepted, timed_out);
        end
        tests_run++;
        if (n_bursts !== 2) begin tests_failed++; $display("FAIL two_bursts: got %0d expected 2", n_bursts); end
        tests_run++;
        if (bstart_acc[1] - bstart_acc[0] !== 16) begin
            tests_failed++;
            $display("FAIL two_band1_pixels: got %0d expected 16", bstart_acc[1] - bstart_acc[0]);
        end
        tests_run++;
        if (sr_after[0] !== 1'b1 || done_after[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_band0_end: got sready=%0d done=%0d expected sready=1 done=0", sr_after[0], done_after[0]);
        end
        tests_run++;
        if (done_after[1] !== 1'b1 || blen[1] !== 4 + 2 * PAD) begin
            tests_failed++;
            $display("FAIL two_band1_end: got done=%0d len=%0d expected done=1 len=%0d", done_after[1], blen[1], 4 + 2 * PAD);
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (cap[blen[0]+PAD+2][k] !== 8'(exp_col2[k])) begin
                tests_failed++;
                $display("FAIL two_band1_col2_buf%0d: got %0d expected %0d", k, cap[blen[0]+PAD+2][k], exp_col2[k]);
            end
        end
    endtask

    task automatic test_short_band();
        run_image(3, 8, 1'b0);
        tests_run++;
        if (timed_out || accepted !== 24) begin
            tests_failed++;
            $display("FAIL short_accepted: got %0d (timeout %0d) expected 24", accepted, timed_out);
        end
        tests_run++;
        if (n_bursts !== 2 || blen[1] !== 3 + 2 * PAD) begin
            tests_failed++;
            $display("FAIL short_bursts: got %0d/%0d expected 2/%0d", n_bursts, blen[1], 3 + 2 * PAD);
        end
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (cap[blen[0]+PAD+c][k] !== (k < 4 ? 8'((4 + k) * 16 + c) : 8'd0)) begin
                    tests_failed++;
                    $display("FAIL short_col%0d_buf%0d: got %0d expected %0d", c, k, cap[blen[0]+PAD+c][k],
                             k < 4 ? (4 + k) * 16 + c : 0);
                end
            end
    endtask

    task automatic test_backpressure();
        run_image(5, 6, 1'b1);
        tests_run++;
        if (timed_out || accepted !== 30) begin
            tests_failed++;
            $display("FAIL bp_accepted: got %0d (timeout %0d) expected 30", accepted, timed_out);
        end
        tests_run++;
        if (n_bursts !== 1 || blen[0] !== 5 + 2 * PAD) begin
            tests_failed++;
            $display("FAIL bp_burst: got %0d bursts len %0d expected 1 len %0d", n_bursts, blen[0], 5 + 2 * PAD);
        end
        tests_run++;
        if (sready_bad !== 0) begin tests_failed++; $display("FAIL bp_sready_stream: got %0d expected 0", sready_bad); end
        for (int c = 0; c < 5; c++)
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (cap[c+PAD][k] !== 8'(k * 16 + c)) begin
                    tests_failed++;
                    $display("FAIL bp_col%0d_buf%0d: got %0d expected %0d", c, k, cap[c+PAD][k], k * 16 + c);
                end
            end
    endtask

    task automatic test_reset_mid_stream();
        int idx;
        bit found;
        idx = 0;
        found = 1'b0;
        @(negedge clk);
        start = 1'b1; img_w = 7'd4; img_h = 7'd6;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            if (idx == 24 && !s_ready) found = 1'b1;
            else begin
                s_valid = 1'b1;
                s_data = 8'((idx / 4) * 16 + (idx % 4));
                if (s_ready) idx++;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL midrst_reach_stream: got no stream expected stream"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s_ready, out_valid, busy, done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: got %b expected 0000", {s_ready, out_valid, busy, done});
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (bufs[k] !== 8'd0) begin
                tests_failed++;
                $display("FAIL midrst_buffer%0d: got %0d expected 0", k, bufs[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic("after_reset");
    endtask

    task automatic test_illegal();
        run_image(4, 2, 1'b0);
        tests_run++;
        if (timed_out || accepted !== 0 || n_bursts !== 0 || busy_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_h2: got acc=%0d bursts=%0d busy=%0d timeout=%0d expected 0 0 0 0",
                     accepted, n_bursts, busy_seen, timed_out);
        end
        run_image(2, 6, 1'b0);
        tests_run++;
        if (timed_out || accepted !== 0 || n_bursts !== 0) begin
            tests_failed++;
            $display("FAIL illegal_w2: got acc=%0d bursts=%0d timeout=%0d expected 0 0 0", accepted, n_bursts, timed_out);
        end
    endtask

`ifdef DWC_FEEDER_HPAD_EN
    task automatic test_hpad();
        run_image(4, 6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (cap[0][k] !== 8'd0 || cap[5][k] !== 8'd0) begin
                tests_failed++;
                $display("FAIL hpad_edge_buf%0d: got %0d/%0d expected 0/0", k, cap[0][k], cap[5][k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic("basic");
        test_two_bands();
        test_short_band();
        test_backpressure();
        test_reset_mid_stream();
        test_illegal();
`ifdef DWC_FEEDER_HPAD_EN
        test_hpad();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
